// File: rtl/neuron_bank_mem.sv
// Double-buffered (ping-pong) neuron activation store with load port, bypass and clear engine.
// Optional build macro BIAS_NEURON_EN: address 0 of either bank reads as fixed-point one.
module neuron_bank_mem #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int DEPTH  = 432,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     swap,
  input  logic                     clear,
  output logic                     busy,
  output logic                     bank_sel,
  output logic                     err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
`ifdef BIAS_NEURON_EN
  localparam logic [DATA_W-1:0] FX_ONE = DATA_W'(1) << FRAC_W;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic              rd_ok, wr_ok, ld_ok;
  logic              wr_go, ld_go, err_set;
  logic              wb_we;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rd_word, rd_next;

  assign rd_ok = (rd_addr <= LAST_ADDR);
  assign wr_ok = (wr_addr <= LAST_ADDR);
  assign ld_ok = (ld_addr <= LAST_ADDR);

  // The clear engine owns the write bank while busy; host writes are dropped then.
  assign wr_go = wr_en & wr_ok & ~busy;
  assign ld_go = ld_en & ld_ok;

  assign err_set = (rd_en & ~rd_ok) | (ld_en & ~ld_ok)
                 | (wr_en & (~wr_ok | busy)) | (swap & busy);

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wb_we   = wr_go;
    wb_idx  = wr_addr[IDX_W-1:0];
    wb_data = wr_data;
    if (state == CLEAR) begin
      wb_we   = 1'b1;
      wb_idx  = clr_idx;
      wb_data = '0;
    end
  end

  always_comb begin
    rd_word = bank_sel ? mem1[rd_addr[IDX_W-1:0]] : mem0[rd_addr[IDX_W-1:0]];
    rd_next = rd_word;
    if (!rd_ok) begin
      rd_next = '0;
    end else begin
      if (ld_go && (ld_addr == rd_addr)) rd_next = ld_data;
`ifdef BIAS_NEURON_EN
      if (rd_addr == '0) rd_next = FX_ONE;
`endif
    end
  end

  // NOTE: storage arrays carry no reset; only control state is reset, so the banks map onto plain RAM.
  always_ff @(posedge clk) begin
    if (bank_sel) begin
      if (ld_go) mem1[ld_addr[IDX_W-1:0]] <= ld_data;
      if (wb_we) mem0[wb_idx]             <= wb_data;
    end else begin
      if (ld_go) mem0[ld_addr[IDX_W-1:0]] <= ld_data;
      if (wb_we) mem1[wb_idx]             <= wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_idx <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state   <= IDLE;
            clr_idx <= '0;
            busy    <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      bank_sel <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
      if (swap && !busy) bank_sel <= ~bank_sel;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neuron_bank_mem.sv
// Directed self-checking bench for neuron_bank_mem (default parameters).
module tb_neuron_bank_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 432;
`ifdef BIAS_NEURON_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rd_en = 1'b0, wr_en = 1'b0, ld_en = 1'b0, swap = 1'b0, clear = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0, ld_addr = '0;
  logic [DATA_W-1:0] wr_data = '0, ld_data = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, busy, bank_sel, err;

  int n_checks = 0;
  int n_pass   = 0;

  neuron_bank_mem #(.DATA_W(DATA_W), .FRAC_W(8), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .swap(swap), .clear(clear), .busy(busy), .bank_sel(bank_sel), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rd_exp(input int a, input logic [15:0] v);
    return (BIAS && a == 0) ? 16'h0100 : v;
  endfunction

  task automatic do_rd(input int a, input logic [15:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = ADDR_W'(a);
    step();
    rd_en = 1'b0;
    check(tag, {16'h0, rd_data}, {16'h0, exp});
    check({tag, "_vld"}, {31'h0, rd_valid}, 32'd1);
  endtask

  task automatic do_ld(input int a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = ADDR_W'(a); ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic do_wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    step();
    swap = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data",  {16'h0, rd_data}, 32'd0);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'd0);
    check("rst_busy",     {31'h0, busy}, 32'd0);
    check("rst_bank_sel", {31'h0, bank_sel}, 32'd0);
    check("rst_err",      {31'h0, err}, 32'd0);
    reset_n = 1'b1;
    step();

    // 1) load bank0 with k*3, read back back-to-back
    for (int k = 0; k < 10; k++) do_ld(k, 16'(k * 3));
    for (int k = 0; k < 10; k++) do_rd(k, rd_exp(k, 16'(k * 3)), $sformatf("t1_rd%0d", k));

    // 2) write bank1, read old value in swap cycle, then new value
    do_wr(5, 16'h0123);
    swap = 1'b1; rd_en = 1'b1; rd_addr = 12'd5;
    step();
    swap = 1'b0; rd_en = 1'b0;
    check("t2_swap_cycle_rd", {16'h0, rd_data}, 32'd15);
    check("t2_bank_sel",      {31'h0, bank_sel}, 32'd1);
    do_rd(5, 16'h0123, "t2_rd_after_swap");

    // 3) load/read bypass on the same address, hold when idle, dual-port on distinct addresses
    ld_en = 1'b1; ld_addr = 12'd7; ld_data = 16'hFFD6;
    rd_en = 1'b1; rd_addr = 12'd7;
    step();
    ld_en = 1'b0; rd_en = 1'b0;
    check("t3_bypass", {16'h0, rd_data}, 32'h0000FFD6);
    step();
    check("t3_idle_vld",  {31'h0, rd_valid}, 32'd0);
    check("t3_idle_hold", {16'h0, rd_data}, 32'h0000FFD6);
    ld_en = 1'b1; ld_addr = 12'd8; ld_data = 16'd77;
    rd_en = 1'b1; rd_addr = 12'd5;
    step();
    ld_en = 1'b0; rd_en = 1'b0;
    check("t3_dual_rd", {16'h0, rd_data}, 32'h00000123);
    do_rd(8, 16'd77, "t3_dual_ld");
    check("t3_err_clean", {31'h0, err}, 32'd0);

    // 4) full clear of bank0 with illegal write/swap/clear mid-way
    clear = 1'b1;
    step();
    clear = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      if (n == 10) begin
        wr_en = 1'b1; wr_addr = 12'd3; wr_data = 16'h5555;
        swap = 1'b1; clear = 1'b1;
      end else begin
        wr_en = 1'b0; swap = 1'b0; clear = 1'b0;
      end
      step();
      n++;
    end
    wr_en = 1'b0; swap = 1'b0; clear = 1'b0;
    check("t4_busy_cycles", n, DEPTH);
    check("t4_err",         {31'h0, err}, 32'd1);
    check("t4_swap_ignored", {31'h0, bank_sel}, 32'd1);
    do_swap();
    check("t4_bank_sel", {31'h0, bank_sel}, 32'd0);
    for (int k = 0; k < 10; k++) do_rd(k, rd_exp(k, 16'h0), $sformatf("t4_rd%0d", k));
    do_rd(DEPTH - 1, 16'h0, "t4_rd_last");

    // 5) reset in the middle of clearing bank1
    do_wr(50,  16'h1111);
    do_wr(99,  16'h2222);
    do_wr(100, 16'h3333);
    do_wr(200, 16'h0BAD);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("t5_busy_before", {31'h0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy",     {31'h0, busy}, 32'd0);
    check("t5_rst_err",      {31'h0, err}, 32'd0);
    check("t5_rst_bank_sel", {31'h0, bank_sel}, 32'd0);
    #2;
    reset_n = 1'b1;
    step();
    do_swap();
    do_rd(5,   16'h0,    "t5_rd5");
    do_rd(50,  16'h0,    "t5_rd50");
    do_rd(99,  16'h0,    "t5_rd99");
    do_rd(100, 16'h3333, "t5_rd100");
    do_rd(200, 16'h0BAD, "t5_rd200");

    // 6) out-of-range read and address-0 behaviour
    check("t6_err_before", {31'h0, err}, 32'd0);
    do_rd(DEPTH, 16'h0, "t6_rd_oob");
    check("t6_err", {31'h0, err}, 32'd1);
    do_ld(0, 16'h7777);
    do_rd(0, rd_exp(0, 16'h7777), "t6_rd_addr0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
